// File: rtl/expr_eval.sv
// ----------------------------------------------------------------------------
// expr_eval
// Streaming evaluator for single-digit arithmetic expressions of the form
// digit ( op digit )*, op in {'+', '*'}, one ASCII character per clock.
// '*' binds tighter than '+'. Runs in lockstep with the expression validator,
// so the value of the prefix appears on the same cycle as its legality.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   clr      : asynchronous active-high reset, returns the block to IDLE
//   in       : ASCII character consumed at every rising edge while clr is low
//   valid    : prefix consumed so far is a complete legal expression
//   result   : value of the prefix when valid, otherwise 0
//   error    : sticky, an illegal character or sequence has been consumed
//   overflow : sticky, some multiply or add has wrapped modulo 2^WIDTH
// ----------------------------------------------------------------------------
module expr_eval #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             overflow
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NUM  = 3'd1,
        ST_ADD  = 3'd2,
        ST_MUL  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // ASCII '0'..'9' share the high nibble 4'h3 with low nibble 0..9.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   sum_r;
    logic [WIDTH-1:0]   term_r;
    logic [WIDTH-1:0]   res_r;
    logic               ovf_r;
    logic [WIDTH-1:0]   sum_nxt_s;
    logic [WIDTH-1:0]   term_nxt_s;
    logic [WIDTH-1:0]   res_nxt_s;
    logic               ovf_nxt_s;

    logic               valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               error_r;
    logic               valid_nxt_s;
    logic [WIDTH-1:0]   result_nxt_s;
    logic               error_nxt_s;

    logic               digit_s;
    logic [WIDTH-1:0]   dig_ext_s;
    logic [WIDTH+3:0]   prod_full_s;
    logic               prod_ovf_s;
    logic [WIDTH-1:0]   new_term_s;
    logic [WIDTH:0]     add_full_s;

    // Datapath: candidate new term (digit or term*digit) and sum+new_term with carry.
    always_comb begin
        digit_s     = is_digit(in);
        dig_ext_s   = {{(WIDTH-4){1'b0}}, in[3:0]};
        prod_full_s = {4'b0000, term_r} * {{WIDTH{1'b0}}, in[3:0]};
        prod_ovf_s  = |prod_full_s[WIDTH+3:WIDTH];
        if (state_r == ST_MUL) begin
            new_term_s = prod_full_s[WIDTH-1:0];
        end else begin
            new_term_s = dig_ext_s;
        end
        add_full_s = {1'b0, sum_r} + {1'b0, new_term_s};
    end

    // Next-state and accumulator update logic.
    always_comb begin
        state_nxt_s = state_r;
        sum_nxt_s   = sum_r;
        term_nxt_s  = term_r;
        res_nxt_s   = res_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            ST_IDLE, ST_ADD: begin
                if (digit_s) begin
                    state_nxt_s = ST_NUM;
                    term_nxt_s  = dig_ext_s;
                    res_nxt_s   = add_full_s[WIDTH-1:0];
                    ovf_nxt_s   = ovf_r | add_full_s[WIDTH];
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            ST_NUM: begin
                if (in == 8'h2B) begin
                    // '+' commits the running value as the new sum
                    state_nxt_s = ST_ADD;
                    sum_nxt_s   = res_r;
                    term_nxt_s  = {WIDTH{1'b0}};
                end else if (in == 8'h2A) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            ST_MUL: begin
                if (digit_s) begin
                    state_nxt_s = ST_NUM;
                    term_nxt_s  = prod_full_s[WIDTH-1:0];
                    res_nxt_s   = add_full_s[WIDTH-1:0];
                    ovf_nxt_s   = ovf_r | prod_ovf_s | add_full_s[WIDTH];
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_ERR;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs reflect the character consumed at this edge.
    always_comb begin
        valid_nxt_s = (state_nxt_s == ST_NUM);
        error_nxt_s = (state_nxt_s == ST_ERR);
        if (valid_nxt_s) begin
            result_nxt_s = res_nxt_s;
        end else begin
            result_nxt_s = {WIDTH{1'b0}};
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            sum_r    <= {WIDTH{1'b0}};
            term_r   <= {WIDTH{1'b0}};
            res_r    <= {WIDTH{1'b0}};
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sum_r    <= sum_nxt_s;
            term_r   <= term_nxt_s;
            res_r    <= res_nxt_s;
            ovf_r    <= ovf_nxt_s;
            valid_r  <= valid_nxt_s;
            result_r <= result_nxt_s;
            error_r  <= error_nxt_s;
        end
    end

    assign valid    = valid_r;
    assign result   = result_r;
    assign error    = error_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_expr_eval.sv
// ----------------------------------------------------------------------------
// tb_expr_eval
// Drives directed character streams into two expr_eval instances (WIDTH=32
// and WIDTH=8). A string-level model re-parses the consumed prefix and
// evaluates it with wide arithmetic; one process compares both instances
// against it every cycle. Literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic [7:0]  in;
    logic        valid32, error32, overflow32;
    logic [31:0] result32;
    logic        valid8, error8, overflow8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;

    expr_eval #(.WIDTH(32)) dut32 (
        .clk(clk), .clr(clr), .in(in),
        .valid(valid32), .result(result32), .error(error32), .overflow(overflow32)
    );

    expr_eval #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .in(in),
        .valid(valid8), .result(result8), .error(error8), .overflow(overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [7:0]  expr_q[$];
    logic        err_m;
    logic        ovf32_m, ovf8_m;
    logic [31:0] val32_m;
    logic [7:0]  val8_m;
    logic        cmp_en;

    // Evaluate a legal prefix ending in a digit; returns {wrapped, value}.
    function automatic logic [64:0] eval_prefix(input logic [7:0] q[$], input int w);
        logic [63:0] mask;
        logic [63:0] sum;
        logic [63:0] term;
        logic [63:0] p;
        logic [63:0] d;
        logic [63:0] t;
        logic        wrap;
        mask = (64'd1 << w) - 64'd1;
        sum  = 64'd0;
        term = 64'd0;
        wrap = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
                d = {56'd0, q[i]} - 64'd48;
                if (i == 0 || q[i-1] == 8'h2B) begin
                    term = d;
                end else begin
                    p = term * d;
                    if (p > mask) wrap = 1'b1;
                    term = p & mask;
                end
            end else if (q[i] == 8'h2B) begin
                sum  = (sum + term) & mask;
                term = 64'd0;
            end
        end
        t = sum + term;
        if (t > mask) wrap = 1'b1;
        return {wrap, t & mask};
    endfunction

    function automatic void model_reset();
        expr_q.delete();
        err_m   = 1'b0;
        ovf32_m = 1'b0;
        ovf8_m  = 1'b0;
        val32_m = 32'd0;
        val8_m  = 8'd0;
    endfunction

    function automatic void model_step(input logic [7:0] c);
        logic        isd;
        logic        isop;
        logic [64:0] r;
        if (!err_m) begin
            isd  = (c >= 8'h30) && (c <= 8'h39);
            isop = (c == 8'h2B) || (c == 8'h2A);
            if (((expr_q.size() % 2) == 0 && isd) || ((expr_q.size() % 2) == 1 && isop)) begin
                expr_q.push_back(c);
                if (isd) begin
                    r = eval_prefix(expr_q, 32);
                    ovf32_m = ovf32_m | r[64];
                    val32_m = r[31:0];
                    r = eval_prefix(expr_q, 8);
                    ovf8_m = ovf8_m | r[64];
                    val8_m = r[7:0];
                end
            end else begin
                err_m = 1'b1;
            end
        end
    endfunction

    function automatic logic exp_valid();
        return !err_m && ((expr_q.size() % 2) == 1);
    endfunction

    // Cycle compare of both instances against the model, on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (valid32 !== exp_valid() || error32 !== err_m || overflow32 !== ovf32_m
                || result32 !== (exp_valid() ? val32_m : 32'd0)) begin
                errors++;
                $display("FAIL cyc32 t=%0t got v=%b r=%0d e=%b o=%b exp v=%b r=%0d e=%b o=%b",
                         $time, valid32, result32, error32, overflow32,
                         exp_valid(), (exp_valid() ? val32_m : 32'd0), err_m, ovf32_m);
            end
            checks++;
            if (valid8 !== exp_valid() || error8 !== err_m || overflow8 !== ovf8_m
                || result8 !== (exp_valid() ? val8_m : 8'd0)) begin
                errors++;
                $display("FAIL cyc8 t=%0t got v=%b r=%0d e=%b o=%b exp v=%b r=%0d e=%b o=%b",
                         $time, valid8, result8, error8, overflow8,
                         exp_valid(), (exp_valid() ? val8_m : 8'd0), err_m, ovf8_m);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] c);
        in = c;
        @(posedge clk);
        #1;
        model_step(c);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    // Pulse clr between edges and check that outputs clear without an edge.
    task automatic pulse_clr(input string name);
        clr = 1'b1;
        #2;
        checks++;
        if (valid32 !== 1'b0 || result32 !== 32'd0 || error32 !== 1'b0 || overflow32 !== 1'b0
            || valid8 !== 1'b0 || result8 !== 8'd0 || error8 !== 1'b0 || overflow8 !== 1'b0) begin
            errors++;
            $display("FAIL %s got v=%b r=%0d e=%b o=%b required all zero",
                     name, valid32, result32, error32, overflow32);
        end
        model_reset();
        #1;
        clr = 1'b0;
    endtask

    // Literal expectation checked against both the WIDTH=32 DUT and the model.
    task automatic lit32(input string name, input logic v, input logic [31:0] r,
                         input logic e, input logic o);
        checks++;
        if (valid32 !== v || result32 !== r || error32 !== e || overflow32 !== o) begin
            errors++;
            $display("FAIL %s dut got v=%b r=%0d e=%b o=%b required v=%b r=%0d e=%b o=%b",
                     name, valid32, result32, error32, overflow32, v, r, e, o);
        end
        checks++;
        if (exp_valid() !== v || (exp_valid() ? val32_m : 32'd0) !== r || err_m !== e || ovf32_m !== o) begin
            errors++;
            $display("FAIL %s model got v=%b r=%0d e=%b o=%b required v=%b r=%0d e=%b o=%b",
                     name, exp_valid(), val32_m, err_m, ovf32_m, v, r, e, o);
        end
    endtask

    task automatic lit8(input string name, input logic v, input logic [7:0] r, input logic o);
        checks++;
        if (valid8 !== v || result8 !== r || overflow8 !== o || ovf8_m !== o
            || (exp_valid() ? val8_m : 8'd0) !== r) begin
            errors++;
            $display("FAIL %s got v=%b r=%0d o=%b model r=%0d o=%b required v=%b r=%0d o=%b",
                     name, valid8, result8, overflow8, val8_m, ovf8_m, v, r, o);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cmp_en = 1'b0;
        clr    = 1'b1;
        in     = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lit32("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        clr    = 1'b0;
        cmp_en = 1'b1;

        // 1+2*3 : (1,1) (0,0) (1,3) (0,0) (1,7)
        send("1"); lit32("p1_1", 1'b1, 32'd1, 1'b0, 1'b0);
        send("+"); lit32("p1_plus", 1'b0, 32'd0, 1'b0, 1'b0);
        send("2"); lit32("p1_2", 1'b1, 32'd3, 1'b0, 1'b0);
        send("*"); lit32("p1_mul", 1'b0, 32'd0, 1'b0, 1'b0);
        send("3"); lit32("p1_3", 1'b1, 32'd7, 1'b0, 1'b0);

        // 9*9*9 : 729 at WIDTH=32, 217 with overflow at WIDTH=8
        pulse_clr("clr_a");
        send_str("9*9");
        lit8("w8_81", 1'b1, 8'd81, 1'b0);
        send_str("*9");
        lit32("w32_729", 1'b1, 32'd729, 1'b0, 1'b0);
        lit8("w8_217", 1'b1, 8'd217, 1'b1);
        // overflow stays set after further terms
        send_str("+1");
        lit8("w8_sticky", 1'b1, 8'd218, 1'b1);

        // 1++2 : error after the second '+', remains through '2'
        pulse_clr("clr_b");
        send_str("1++");
        lit32("dblplus", 1'b0, 32'd0, 1'b1, 1'b0);
        send("2");
        lit32("err_hold", 1'b0, 32'd0, 1'b1, 1'b0);
        pulse_clr("clr_c");
        send("4");
        lit32("after_err", 1'b1, 32'd4, 1'b0, 1'b0);

        // leading operator, non-symbol byte, digit-digit
        pulse_clr("clr_d");
        send("+");
        lit32("lead_op", 1'b0, 32'd0, 1'b1, 1'b0);
        pulse_clr("clr_e");
        send("a");
        lit32("bad_byte", 1'b0, 32'd0, 1'b1, 1'b0);
        pulse_clr("clr_f");
        send("1");
        send("2");
        lit32("dig_dig", 1'b0, 32'd0, 1'b1, 1'b0);

        // 5* then async clr, then 4 proves term state discarded
        pulse_clr("clr_g");
        send_str("5*");
        pulse_clr("clr_mid");
        send("4");
        lit32("discard", 1'b1, 32'd4, 1'b0, 1'b0);

        // async clr while valid high clears result immediately
        pulse_clr("clr_h");
        send("7");
        lit32("pre_clr7", 1'b1, 32'd7, 1'b0, 1'b0);
        pulse_clr("clr_valid");

        // 3*0+5*2 : 3, 0, 5, 10
        send("3"); lit32("z_3", 1'b1, 32'd3, 1'b0, 1'b0);
        send("*");
        send("0"); lit32("z_0", 1'b1, 32'd0, 1'b0, 1'b0);
        send("+");
        send("5"); lit32("z_5", 1'b1, 32'd5, 1'b0, 1'b0);
        send("*");
        send("2"); lit32("z_10", 1'b1, 32'd10, 1'b0, 1'b0);

        // clr held across an edge: input ignored
        in  = "8";
        clr = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        lit32("clr_edge", 1'b0, 32'd0, 1'b0, 1'b0);
        clr = 1'b0;
        send_str("8+8*8");
        lit32("after_clr_edge", 1'b1, 32'd72, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming evaluator for single-digit arithmetic expressions of the form digit ( op digit )*, op ∈ {'+', '*'}, one ASCII character per clock. It sits directly downstream of the expression validator and consumes the same character stream in lockstep. It computes the running value of the prefix with '*' binding tighter than '+', so the validator's "legal" flag and this block's value are available on the same cycle. Illegal syntax latches a sticky error until clear.

## Interface
- WIDTH, 32, width of the accumulators and the result; all arithmetic is modulo 2^WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high; returns the block to IDLE.
- in  input  8  ASCII character consumed at each rising edge while clr is low.
- valid  output  1  high when the characters consumed so far form a complete legal expression (last char a digit, no error).
- result  output  WIDTH  value of the expression consumed so far when valid=1; 0 when valid=0.
- error  output  1  sticky; high once an illegal character or sequence has been consumed.
- overflow  output  1  sticky; high once any multiply or add in the evaluation has wrapped modulo 2^WIDTH.

## Operation
- Digit: in ∈ "0".."9", value d = in − "0". Operator: in == "+" or in == "*". Any other byte is illegal.
- Registers: state, sum (committed terms), term (current product), res (= sum + term), ovf.
- States and transitions, evaluated at each edge:
  - IDLE: digit → NUM, term=d, res=sum+d (sum=0). Other → ERR.
  - NUM: '+' → ADD, sum=res, term=0. '*' → MUL. Digit or illegal → ERR.
  - ADD: digit → NUM, term=d, res=sum+d. Other → ERR.
  - MUL: digit → NUM, term=term·d, res=sum+term·d. Other → ERR.
  - ERR: absorbing; nothing is consumed.
- Arithmetic: term·d and sum+term are computed at full width and truncated to WIDTH. ovf is set on a digit edge if the product exceeds 2^WIDTH−1 or if sum+new_term carries out. It is never cleared except by clr.
- Outputs:
  - valid = (state==NUM).
  - error = (state==ERR).
  - result = valid ? res : 0.
  - overflow = ovf.
- A zero digit is legal. "3*0" yields 0, and a later "+5" yields 5.

## Timing
- Reset values (clr high, asynchronous, immediate without waiting for an edge): state=IDLE, sum=term=res=0, ovf=0. So valid=0, result=0, error=0, overflow=0.
- Latency: the effect of the character sampled at edge k is visible on all outputs after edge k. This matches the validator's output timing cycle-for-cycle.
- clr asserted mid-expression discards all partial results. The first edge after clr deasserts consumes a first character from IDLE.
- clr and an edge in the same cycle: clr wins and in is ignored.
- Once in ERR, error=1, valid=0 and result=0 hold regardless of input until clr. overflow retains its pre-error value.
- No handshake: every edge with clr low consumes exactly one character. The upstream must hold in stable around the edge.

## Test plan
- "1+2*3" on consecutive edges → after each edge (valid,result): (1,1) (0,0) (1,3) (0,0) (1,7). error=0, overflow=0.
- "9*9*9" with WIDTH=32 → final valid=1, result=729, overflow=0. Same stream with WIDTH=8 → result=217, overflow=1 from the third digit onward.
- "1++2" → error=1 after the second '+'. The following '2' leaves error=1, valid=0, result=0. clr then "4" → valid=1, result=4, error=0.
- Leading operator "+", then a non-symbol byte "a" in a fresh run, then digit-digit "12" in a fresh run → error=1 at the first, first and second edge respectively.
- "5*" then clr pulsed between edges → outputs go to 0 without a clock edge. Then "4" → valid=1, result=4, proving term state was discarded.
- "3*0+5*2" → valid results 3, 0, 5, 10 after each digit. overflow stays 0.
